// File: rtl/kbd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kbd_scan_ctrl: drains PS/2 Set-2 bytes, assembles key events into a FIFO,   |
// | tracks shift/ctrl/caps. Optional macro: KBD_TYPEMATIC_FILTER_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module kbd_scan_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  input  logic       ev_ack,
  output logic       shift,
  output logic       ctrl,
  output logic       caps,
  output logic [1:0] err,
  input  logic       err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  byte_r;
  logic        ext_p;
  logic        brk_p;
  logic        lshift;
  logic        rshift;
  logic        caps_h;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [9:0]  mem [FIFO_DEPTH];
  logic [9:0]  head;

  logic full;
  logic push;
  logic perr;
  logic clr_flags;
  logic set_ext;
  logic set_brk;
  logic dup;
  logic ack;

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [7:0] last_code;
  logic       last_ext;
  logic       last_vld;
  assign dup = !brk_p && last_vld && (last_code == byte_r) && (last_ext == ext_p);
`else
  assign dup = 1'b0;
`endif

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ev_valid = (wr_ptr != rd_ptr);
  assign ack      = ev_ack && ev_valid;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign ev_code  = ev_valid ? head[7:0] : 8'h00;
  assign ev_brk   = ev_valid & head[8];
  assign ev_ext   = ev_valid & head[9];
  assign shift    = lshift | rshift;

  always_comb begin
    push      = 1'b0;
    perr      = 1'b0;
    clr_flags = 1'b0;
    set_ext   = 1'b0;
    set_brk   = 1'b0;
    if (state == POP) begin
      case (byte_r)
        8'hE0: set_ext = 1'b1;
        8'hF0: begin
          if (brk_p) begin
            perr      = 1'b1;
            clr_flags = 1'b1;
          end else begin
            set_brk = 1'b1;
          end
        end
        8'h00, 8'hFF: begin
          perr      = 1'b1;
          clr_flags = 1'b1;
        end
        // Keyboard controller responses carry no key information.
        8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
        end
        default: begin
          clr_flags = 1'b1;
          push      = !dup;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {ext_p, brk_p, byte_r};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      byte_r     <= 8'h00;
      nextdata_n <= 1'b1;
      ext_p      <= 1'b0;
      brk_p      <= 1'b0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      ctrl       <= 1'b0;
      caps       <= 1'b0;
      caps_h     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err        <= 2'b00;
`ifdef KBD_TYPEMATIC_FILTER_EN
      last_code  <= 8'h00;
      last_ext   <= 1'b0;
      last_vld   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ready && !full) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          state      <= WAIT;
        end
        WAIT: state <= IDLE;
        default: begin
          nextdata_n <= 1'b1;
          state      <= IDLE;
        end
      endcase

      if (clr_flags) begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end else begin
        if (set_ext) ext_p <= 1'b1;
        if (set_brk) brk_p <= 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (!ext_p && byte_r == 8'h12) lshift <= !brk_p;
        if (!ext_p && byte_r == 8'h59) rshift <= !brk_p;
        if (byte_r == 8'h14) ctrl <= !brk_p;
        // Caps toggles once per physical press; repeats see caps_h already set.
        if (byte_r == 8'h58) begin
          if (brk_p) begin
            caps_h <= 1'b0;
          end else if (!caps_h) begin
            caps   <= ~caps;
            caps_h <= 1'b1;
          end
        end
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (!brk_p) begin
          last_code <= byte_r;
          last_ext  <= ext_p;
          last_vld  <= 1'b1;
        end else if (last_code == byte_r && last_ext == ext_p) begin
          last_vld <= 1'b0;
        end
`endif
      end

      if (ack) rd_ptr <= rd_ptr + (AW+1)'(1);

      err[0] <= (err[0] & ~err_clr) | overflow;
      err[1] <= (err[1] & ~err_clr) | perr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_kbd_scan_ctrl: scoreboard bench for kbd_scan_ctrl with a PS/2 byte model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_kbd_scan_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;
  logic       ev_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       nextdata_n;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       shift;
  logic       ctrl;
  logic       caps;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit auto_ack = 1'b0;
  logic [7:0] ps2_q[$];
  logic [9:0] exp_q[$];

  kbd_scan_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_ack(ev_ack), .shift(shift),
    .ctrl(ctrl), .caps(caps), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // PS/2 source: a byte leaves the queue on each edge where the pop strobe is low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!nextdata_n && ps2_q.size() > 0) void'(ps2_q.pop_front());
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected completion");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    ps2_q.push_back(b);
  endtask

  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  // One cycle: refresh the PS/2 model outputs and service the consumer side.
  task automatic tick();
    logic [9:0] exp;
    @(negedge clk);
    ready = (ps2_q.size() > 0);
    data  = (ps2_q.size() > 0) ? ps2_q[0] : 8'h00;
    if (auto_ack && ev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ext=%b brk=%b code=%h, expected no event", ev_ext, ev_brk, ev_code);
      end else begin
        exp = exp_q.pop_front();
        if ({ev_ext, ev_brk, ev_code} !== exp) begin
          errors++;
          $display("FAIL sb_event: got ext=%b brk=%b code=%h, expected ext=%b brk=%b code=%h",
                   ev_ext, ev_brk, ev_code, exp[9], exp[8], exp[7:0]);
        end
      end
      ev_ack = 1'b1;
    end else begin
      ev_ack = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      tick();
      if (ps2_q.size() == 0 && nextdata_n && !(auto_ack && ev_valid)) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s_timeout: got busy after 300 cycles, expected idle", name);
    end
    if (auto_ack) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL %s_missing: got %0d events still expected, expected 0", name, exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) tick();
    checks++;
    if (nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata_n: got %b expected 1", nextdata_n); end
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_ev_valid: got %b expected 0", ev_valid); end
    checks++;
    if ({ev_code, ev_ext, ev_brk} !== 10'h0) begin
      errors++; $display("FAIL rst_event: got code=%h ext=%b brk=%b expected all 0", ev_code, ev_ext, ev_brk);
    end
    checks++;
    if ({shift, ctrl, caps} !== 3'b000) begin errors++; $display("FAIL rst_mods: got %b expected 000", {shift, ctrl, caps}); end
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", err); end
    clr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_make_break();
    int p[$];
    int vr = -1;
    auto_ack = 1'b0;
    expect_ev(1'b0, 1'b0, 8'h1C);
    expect_ev(1'b0, 1'b1, 8'h1C);
    send(8'h1C); send(8'hF0); send(8'h1C);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!nextdata_n) p.push_back(cyc);
      if (ev_valid && vr < 0) vr = cyc;
    end
    checks++;
    if (p.size() != 3) begin
      errors++; $display("FAIL mb_pulse_count: got %0d low cycles expected 3", p.size());
    end else begin
      checks++;
      if (p[1] - p[0] != 3 || p[2] - p[1] != 3) begin
        errors++; $display("FAIL mb_pulse_spacing: got %0d,%0d expected 3,3", p[1] - p[0], p[2] - p[1]);
      end
      checks++;
      if (vr != p[0] + 1) begin
        errors++; $display("FAIL mb_valid_latency: got cycle %0d expected %0d", vr, p[0] + 1);
      end
    end
    auto_ack = 1'b1;
    wait_idle("mb");
  endtask

  task automatic test_extended();
    auto_ack = 1'b1;
    expect_ev(1'b1, 1'b0, 8'h75);
    expect_ev(1'b1, 1'b1, 8'h75);
    send(8'hE0); send(8'h75); send(8'hAA); send(8'hE0); send(8'hF0); send(8'h75);
    wait_idle("ext");
    expect_ev(1'b1, 1'b0, 8'h14);
    send(8'hE0); send(8'h14);
    wait_idle("ext_ctrl_make");
    checks++;
    if ({ctrl, shift} !== 2'b10) begin errors++; $display("FAIL ext_ctrl_make: got ctrl,shift=%b expected 10", {ctrl, shift}); end
    expect_ev(1'b1, 1'b1, 8'h14);
    send(8'hE0); send(8'hF0); send(8'h14);
    wait_idle("ext_ctrl_brk");
    checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL ext_ctrl_brk: got %b expected 0", ctrl); end
  endtask

  task automatic test_modifiers();
    auto_ack = 1'b1;
    expect_ev(1'b0, 1'b0, 8'h12);
    send(8'h12);
    wait_idle("mod_shift");
    checks++;
    if ({shift, caps} !== 2'b10) begin errors++; $display("FAIL mod_shift_make: got shift,caps=%b expected 10", {shift, caps}); end
    expect_ev(1'b0, 1'b0, 8'h58);
    send(8'h58);
    wait_idle("mod_caps1");
    checks++;
    if (caps !== 1'b1) begin errors++; $display("FAIL mod_caps_first: got %b expected 1", caps); end
`ifndef KBD_TYPEMATIC_FILTER_EN
    expect_ev(1'b0, 1'b0, 8'h58);
    expect_ev(1'b0, 1'b0, 8'h58);
`endif
    send(8'h58); send(8'h58);
    wait_idle("mod_caps_rep");
    checks++;
    if (caps !== 1'b1) begin errors++; $display("FAIL mod_caps_repeat: got %b expected 1", caps); end
    expect_ev(1'b0, 1'b1, 8'h58);
    send(8'hF0); send(8'h58);
    wait_idle("mod_caps_brk");
    checks++;
    if ({shift, caps} !== 2'b11) begin errors++; $display("FAIL mod_caps_brk: got shift,caps=%b expected 11", {shift, caps}); end
    expect_ev(1'b0, 1'b1, 8'h12);
    send(8'hF0); send(8'h12);
    wait_idle("mod_shift_brk");
    checks++;
    if ({shift, caps} !== 2'b01) begin errors++; $display("FAIL mod_shift_brk: got shift,caps=%b expected 01", {shift, caps}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    int n = 0;
    auto_ack = 1'b0;
    foreach (codes[i]) begin
      expect_ev(1'b0, 1'b0, codes[i]);
      send(codes[i]);
    end
    repeat (30) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!nextdata_n) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL bp_no_pop: got %0d pops while full expected 0", n); end
    checks++;
    if (ready !== 1'b1 || ps2_q.size() != 2) begin
      errors++; $display("FAIL bp_pending: got ready=%b left=%0d expected ready=1 left=2", ready, ps2_q.size());
    end
    checks++;
    if (ev_valid !== 1'b1 || ev_code !== 8'h1C) begin
      errors++; $display("FAIL bp_head: got valid=%b code=%h expected valid=1 code=1c", ev_valid, ev_code);
    end
    auto_ack = 1'b1;
    wait_idle("bp_drain");
  endtask

  task automatic test_errors();
    auto_ack = 1'b1;
    expect_ev(1'b0, 1'b0, 8'h1C);
    send(8'hF0); send(8'hF0); send(8'h1C); send(8'h00);
    wait_idle("err_proto");
    checks++;
    if (err !== 2'b10) begin errors++; $display("FAIL err_proto: got %b expected 10", err); end
    overflow = 1'b1; tick(); overflow = 1'b0; tick();
    checks++;
    if (err !== 2'b11) begin errors++; $display("FAIL err_overflow: got %b expected 11", err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL err_clear: got %b expected 00", err); end
    err_clr = 1'b1; overflow = 1'b1; tick(); err_clr = 1'b0; overflow = 1'b0; tick();
    checks++;
    if (err !== 2'b01) begin errors++; $display("FAIL err_set_wins: got %b expected 01", err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
  endtask

  task automatic test_reset_midseq();
    bit seen = 1'b0;
    auto_ack = 1'b0;
    send(8'h12); send(8'h1C);
    wait_idle("mid_fill");
    checks++;
    if (ev_valid !== 1'b1 || shift !== 1'b1) begin
      errors++; $display("FAIL mid_prefill: got valid=%b shift=%b expected 1 1", ev_valid, shift);
    end
    send(8'h32);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (!nextdata_n) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_pop_timeout: got no POP in 20 cycles expected one"); end
    clr = 1'b1;
    tick();
    checks++;
    if (ev_valid !== 1'b0 || nextdata_n !== 1'b1) begin
      errors++; $display("FAIL mid_reset_fifo: got valid=%b nextdata_n=%b expected 0 1", ev_valid, nextdata_n);
    end
    checks++;
    if ({shift, ctrl, caps} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_mods: got %b expected 000", {shift, ctrl, caps});
    end
    ps2_q.delete();
    exp_q.delete();
    tick();
    clr = 1'b0;
    repeat (2) tick();
    auto_ack = 1'b1;
    expect_ev(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    wait_idle("mid_after");
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_modifiers();
    test_back_to_back();
    test_errors();
    test_reset_midseq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
